// File: rtl/ext_irq_controller.sv
// External interrupt source controller: edge-captured pending bits, memory-mapped mask,
// lowest-index priority, four-phase ExtIRQ/ExtlAck handshake. Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer.
module ext_irq_controller #(
  parameter int             N         = 64,
  parameter int             NSRC      = 4,
  parameter logic [N-1:0]   MASK_ADDR = 64'h0000_0000_0000_0100
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [NSRC-1:0]           irq_src,
  input  logic                      ExtlAck,
  input  logic                      DM_writeEnable,
  input  logic [N-1:0]              DM_addr,
  input  logic [N-1:0]              DM_writeData,
  output logic                      ExtIRQ,
  output logic [$clog2(NSRC)-1:0]   irq_id,
  output logic [NSRC-1:0]           pending,
  output logic [NSRC-1:0]           irq_mask
);

  localparam int IDW = $clog2(NSRC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_extirq;
  logic              w_extirq_nxt;
  logic [IDW-1:0]    r_irq_id;
  logic [IDW-1:0]    w_irq_id_nxt;
  logic [NSRC-1:0]   r_prev;
  logic [NSRC-1:0]   r_pending;
  logic [NSRC-1:0]   r_mask;
  logic [NSRC-1:0]   w_src;
  logic [NSRC-1:0]   w_edge;
  logic [NSRC-1:0]   w_clr;
  logic [NSRC-1:0]   w_eligible;
  logic [IDW-1:0]    w_winner;
  logic              w_ack_take;
  logic              w_mask_wr;
  logic              w_unused_data;

  function automatic logic [IDW-1:0] f_lowest(input logic [NSRC-1:0] v);
    logic [IDW-1:0] idx;
    idx = {IDW{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;

  // Two-stage synchronizer for peripherals asynchronous to CLOCK_50
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= {NSRC{1'b0}};
      r_sync2 <= {NSRC{1'b0}};
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end
  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_edge        = w_src & ~r_prev;
  assign w_ack_take    = (r_state == S_ASSERT) && ExtlAck;
  assign w_clr         = w_ack_take ? ({{(NSRC-1){1'b0}}, 1'b1} << r_irq_id) : {NSRC{1'b0}};
  assign w_mask_wr     = DM_writeEnable && (DM_addr == MASK_ADDR);
  assign w_eligible    = r_pending & ~r_mask;
  assign w_winner      = f_lowest(w_eligible);
  assign w_unused_data = ^DM_writeData[N-1:NSRC];

  // Edge history, pending capture (a new edge beats an ack clear) and mask register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_prev    <= {NSRC{1'b0}};
      r_pending <= {NSRC{1'b0}};
      r_mask    <= {NSRC{1'b0}};
    end else begin
      r_prev    <= w_src;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (w_mask_wr) begin
        r_mask <= DM_writeData[NSRC-1:0];
      end else begin
        r_mask <= r_mask;
      end
    end
  end

  // FSM state register together with the registered request outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_extirq <= 1'b0;
      r_irq_id <= {IDW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_extirq <= w_extirq_nxt;
      r_irq_id <= w_irq_id_nxt;
    end
  end

  // FSM next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_eligible != {NSRC{1'b0}}) w_state_nxt = S_ASSERT;
        else                            w_state_nxt = S_IDLE;
      end
      S_ASSERT: begin
        if (ExtlAck) w_state_nxt = S_RELEASE;
        else         w_state_nxt = S_ASSERT;
      end
      S_RELEASE: begin
        if (!ExtlAck) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_RELEASE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so they can be registered
  always_comb begin
    w_extirq_nxt = 1'b0;
    w_irq_id_nxt = r_irq_id;
    case (w_state_nxt)
      S_ASSERT: begin
        w_extirq_nxt = 1'b1;
        if (r_state == S_IDLE) w_irq_id_nxt = w_winner;
        else                   w_irq_id_nxt = r_irq_id;
      end
      S_IDLE, S_RELEASE: begin
        w_extirq_nxt = 1'b0;
        w_irq_id_nxt = r_irq_id;
      end
      default: begin
        w_extirq_nxt = 1'b0;
        w_irq_id_nxt = r_irq_id;
      end
    endcase
  end

  assign ExtIRQ   = r_extirq;
  assign irq_id   = r_irq_id;
  assign pending  = r_pending;
  assign irq_mask = r_mask;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed bench for ext_irq_controller (default build): vector table plus hand-written reset sequences.
module tb_ext_irq_controller;

  logic        clk;
  logic        rst_n_s;
  logic [3:0]  src_s;
  logic        ack_s;
  logic        we_s;
  logic [63:0] addr_s;
  logic [63:0] wdata_s;
  logic        irq_s;
  logic [1:0]  id_s;
  logic [3:0]  pend_s;
  logic [3:0]  mask_s;

  int checks;
  int errors;

  localparam logic [63:0] MA = 64'h0000_0000_0000_0100;

  typedef struct {
    logic [3:0]  src;
    logic        ack;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        e_irq;
    logic [1:0]  e_id;
    logic [3:0]  e_pend;
    logic [3:0]  e_mask;
  } vec_t;

  vec_t vecs[$];

  ext_irq_controller dut (
    .CLOCK_50       (clk),
    .reset          (rst_n_s),
    .irq_src        (src_s),
    .ExtlAck        (ack_s),
    .DM_writeEnable (we_s),
    .DM_addr        (addr_s),
    .DM_writeData   (wdata_s),
    .ExtIRQ         (irq_s),
    .irq_id         (id_s),
    .pending        (pend_s),
    .irq_mask       (mask_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] src, input logic ack, input logic we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic e_irq, input logic [1:0] e_id,
                              input logic [3:0] e_pend, input logic [3:0] e_mask);
    vec_t v;
    v.src = src; v.ack = ack; v.we = we; v.addr = addr; v.wdata = wdata;
    v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_full(input string name, input logic e_irq, input logic [1:0] e_id,
                            input logic [3:0] e_pend, input logic [3:0] e_mask);
    checks++;
    if (irq_s !== e_irq || id_s !== e_id || pend_s !== e_pend || mask_s !== e_mask) begin
      errors++;
      $display("FAIL %s: got irq=%b id=%0d pend=%b mask=%b, expected irq=%b id=%0d pend=%b mask=%b",
               name, irq_s, id_s, pend_s, mask_s, e_irq, e_id, e_pend, e_mask);
    end
  endtask

  task automatic check_idle(input string name, input logic [3:0] e_pend, input logic [3:0] e_mask);
    checks++;
    if (irq_s !== 1'b0 || pend_s !== e_pend || mask_s !== e_mask) begin
      errors++;
      $display("FAIL %s: got irq=%b pend=%b mask=%b, expected irq=0 pend=%b mask=%b",
               name, irq_s, pend_s, mask_s, e_pend, e_mask);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n_s = 1'b0;
    src_s = 4'b0000; ack_s = 1'b0; we_s = 1'b0; addr_s = 64'h0; wdata_s = 64'h0;

    // Source 2 single request, ack 3 cycles after ExtIRQ, release 2 cycles later
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    // Sources 1 and 3 together: lowest index first
    vecs.push_back(mk(4'b1010, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd1, 4'b1010, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd3, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd3, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1010, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd3, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd3, 4'b0000, 4'b0000));
    // Mask source 0, pend while masked, wrong address ignored, unmask releases request
    vecs.push_back(mk(4'b0000, 1'b0, 1'b1, MA,              64'h1, 1'b0, 2'd3, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0,           64'h0, 1'b0, 2'd3, 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0,           64'h0, 1'b0, 2'd3, 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b1, MA + 64'd8,      64'h0, 1'b0, 2'd3, 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b1, MA,              64'h0, 1'b0, 2'd3, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0,           64'h0, 1'b1, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 64'h0,           64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0,           64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0,           64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    // Ack while idle is ignored
    vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    // Source 2 re-edges on the ack edge: set wins, second request for 2
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd2, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0000, 4'b0000));
    // Mask change during ASSERT keeps ExtIRQ and irq_id
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd2, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 2'd0, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b1, MA,    64'h1, 1'b1, 2'd0, 4'b0001, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0000, 4'b0001));
    vecs.push_back(mk(4'b0001, 1'b0, 1'b1, MA,    64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 2'd0, 4'b0000, 4'b0000));

    // Reset held with no stimulus, then idle
    repeat (3) step();
    check_full("reset_hold", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst_n_s = 1'b1;
    repeat (10) step();
    check_full("post_reset_10", 1'b0, 2'd0, 4'b0000, 4'b0000);

    for (int k = 0; k < vecs.size(); k++) begin
      src_s = vecs[k].src; ack_s = vecs[k].ack; we_s = vecs[k].we;
      addr_s = vecs[k].addr; wdata_s = vecs[k].wdata;
      step();
      check_full($sformatf("vec%0d", k), vecs[k].e_irq, vecs[k].e_id, vecs[k].e_pend, vecs[k].e_mask);
    end

    // Async reset in ASSERT with two sources pending
    src_s = 4'b0011; ack_s = 1'b0; we_s = 1'b0;
    step();
    check_full("pre_rst_pend", 1'b0, 2'd0, 4'b0011, 4'b0000);
    step();
    check_full("pre_rst_assert", 1'b1, 2'd0, 4'b0011, 4'b0000);
    #2;
    rst_n_s = 1'b0;
    #1;
    check_full("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
    src_s = 4'b0000;
    step();
    rst_n_s = 1'b1;
    repeat (5) step();
    check_idle("no_req_after_rst", 4'b0000, 4'b0000);
    src_s = 4'b0100;
    step();
    check_full("new_edge_pend", 1'b0, 2'd0, 4'b0100, 4'b0000);
    step();
    check_full("new_edge_req", 1'b1, 2'd2, 4'b0100, 4'b0000);
    ack_s = 1'b1;
    step();
    ack_s = 1'b0;
    src_s = 4'b0000;
    step();
    check_idle("final_idle", 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_irq_controller.md
# ext_irq_controller

Interrupt source block driving the processor's external-interrupt handshake (ExtIRQ out, ExtlAck in). Captures rising edges on up to NSRC peripheral interrupt lines, holds them pending, and presents the highest-priority unmasked one to the core. The core acknowledges with a four-phase handshake. A memory-mapped mask register is written from the core's data-memory write port (DM_writeEnable/DM_addr/DM_writeData). Sits beside processor_arm at the top level.

## Interface
- N, 64, data-memory address/data width
- NSRC, 4, number of interrupt sources (2..16)
- MASK_ADDR, 64'h0000_0000_0000_0100, DM byte address of the mask register
- CLOCK_50  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- irq_src  input  NSRC  peripheral interrupt lines, rising-edge triggered
- ExtlAck  input  1  acknowledge from core
- DM_writeEnable  input  1  core data-memory write strobe
- DM_addr  input  N  core data-memory address
- DM_writeData  input  N  core data-memory write data
- ExtIRQ  output  1  interrupt request to core
- irq_id  output  $clog2(NSRC)  index of source being requested; valid while ExtIRQ=1
- pending  output  NSRC  current pending bits (status)
- irq_mask  output  NSRC  current mask (1 = source disabled)

## Operation
- Edge detect: prev register per source; edge[i] = sampled irq_src[i] & ~prev[i]. Edge sets pending[i].
- Repeated edges on an already-pending source collapse into one pending event.
- Mask write: DM_writeEnable=1 and DM_addr==MASK_ADDR -> irq_mask <= DM_writeData[NSRC-1:0] next edge. Other addresses ignored.
- Masked sources still latch pending; they become eligible once unmasked.
- Eligible = pending & ~irq_mask. Priority: lowest index wins.
- FSM states:
  - IDLE: ExtIRQ=0. If eligible!=0 -> ASSERT; latch irq_id = winner.
  - ASSERT: ExtIRQ=1, irq_id held. On ExtlAck=1: clear pending[irq_id], -> RELEASE.
  - RELEASE: ExtIRQ=0. Wait for ExtlAck=0 -> IDLE.
- Simultaneous edge on source irq_id and its ack clear: set wins; the source stays pending.
- Mask change during ASSERT does not retract ExtIRQ or change irq_id.
- ExtlAck=1 in IDLE is ignored.
- reset (async low, mid-operation included): state IDLE; ExtIRQ=0, irq_id=0, pending=0, irq_mask=0, prev=0, synchronizer stages=0.

## Timing
- All outputs registered.
- Without sync: pending[i] set at the first edge that samples irq_src[i]=1 after a 0. ExtIRQ rises one cycle later.
- With IRQ_SYNC_EN: two extra cycles of latency.
- Ack: ExtIRQ falls and the pending bit clears at the first edge sampling ExtlAck=1.
- Earliest next ExtIRQ: one cycle after the edge that samples ExtlAck=0 in RELEASE. Minimum gap between requests is 2 cycles.
- Mask write takes effect for the IDLE decision on the cycle after the write edge.

## Configuration
- IRQ_SYNC_EN defined: irq_src passes through a 2-flop synchronizer before edge detection. Use for asynchronous peripherals. Adds 2 cycles latency.
- IRQ_SYNC_EN undefined: irq_src is sampled directly and must be synchronous to CLOCK_50.

## Test plan
- Reset drop, no stimulus for 10 cycles -> ExtIRQ=0, pending=0, irq_mask=0. ExtlAck pulse in IDLE -> no change.
- irq_src=4'b0100 rising, core acks 3 cycles after ExtIRQ, releases 2 cycles later -> ExtIRQ high 1 cycle after pending[2], irq_id=2, pending=0 after ack, ExtIRQ stays low.
- irq_src 4'b1010 rising same cycle -> first request irq_id=1; after handshake, second request irq_id=3; pending=0 at end.
- Write DM_addr=MASK_ADDR, DM_writeData=64'h1, then edge on source 0 -> pending=4'b0001, no ExtIRQ. Write mask 0 -> ExtIRQ with irq_id=0 next cycle. Write to MASK_ADDR+8 -> mask unchanged.
- Source 2 re-edges on the same cycle ExtlAck is sampled for irq_id=2 -> pending[2] stays 1; second request irq_id=2 after release.
- Assert reset while in ASSERT with pending=4'b0011 -> ExtIRQ=0 and pending=0 immediately (asynchronous). No request after release until a new edge.
